// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register
// offsets, source count and CTRL/STATUS bit positions.
package intc_pkg;

    localparam int NUM_SRC = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARB     = 2'd1,
        ST_ASSERT  = 2'd2,
        ST_RELEASE = 2'd3
    } intc_state_e;

    localparam logic [1:0] REG_MASK    = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int CTRL_EN_BIT     = 7;
    localparam int CTRL_RR_BIT     = 0;
    localparam int STATUS_BUSY_BIT = 7;

endpackage

// File: rtl/irq_arbiter.sv
// Combinational arbiter: fixed priority (lowest index) or round-robin
// starting one past the last served source.
module irq_arbiter
    import intc_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic               rr_mode,
    input  logic [1:0]         last_served,
    output logic [1:0]         grant_id,
    output logic               valid
);

    logic [1:0] start;
    logic [1:0] idx;

    always_comb begin
        grant_id = 2'd0;
        valid    = 1'b0;
        idx      = 2'd0;
        start    = rr_mode ? last_served + 2'd1 : 2'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = start + 2'(i);
            if (!valid && req[idx]) begin
                valid    = 1'b1;
                grant_id = idx;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Four-source interrupt controller with a bus-mapped register window,
// synchronized edge capture and an IDLE/ARB/ASSERT/RELEASE handshake FSM.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for an enabled, unmasked pending source
// ST_ARB     | latch arbiter winner into MCU_IRQ_ID
// ST_ASSERT  | MCU_IRQ high, waiting for ACK or withdrawal of the source
// ST_RELEASE | ACK taken, waiting for MCU_IRQ_ACK to drop
module interrupt_controller
    import intc_pkg::*;
#(
    parameter logic [7:0] IntcBaseAddr  = 8'hE0,
    parameter logic [3:0] InitialMask   = 4'hF,
    parameter logic       InitialEnable = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    input  logic [3:0] IRQ_RAISE,
    output logic       MCU_IRQ,
    output logic [1:0] MCU_IRQ_ID,
    input  logic       MCU_IRQ_ACK
);

    intc_state_e state;
    logic [3:0]  sync1, sync2, sync3;
    logic [3:0]  pending, mask;
    logic        en, rr;
    logic [1:0]  last_served;

    logic [7:0]  off;
    logic        hit, wr;
    logic [3:0]  rise, w1c, ack_clr;
    logic [3:0]  pending_nxt, mask_nxt;
    logic        en_nxt, rr_nxt;
    logic        ack_fire;
    logic [7:0]  rdata;
    logic [1:0]  grant_id;
    logic        grant_valid;

    always_comb begin
        off         = BUS_ADDR - IntcBaseAddr;
        hit         = (off[7:2] == 6'd0);
        wr          = hit && BUS_WE;
        rise        = sync2 & ~sync3;
        w1c         = (wr && off[1:0] == REG_PENDING) ? BUS_DATA[3:0] : 4'h0;
        ack_fire    = (state == ST_ASSERT) && MCU_IRQ_ACK;
        ack_clr     = ack_fire ? (4'h1 << MCU_IRQ_ID) : 4'h0;
        // A fresh edge wins over any clear in the same cycle
        pending_nxt = (pending & ~(w1c | ack_clr)) | rise;
        mask_nxt    = (wr && off[1:0] == REG_MASK) ? BUS_DATA[3:0] : mask;
        en_nxt      = (wr && off[1:0] == REG_CTRL) ? BUS_DATA[CTRL_EN_BIT] : en;
        rr_nxt      = (wr && off[1:0] == REG_CTRL) ? BUS_DATA[CTRL_RR_BIT] : rr;
        rdata       = 8'h00;
        case (off[1:0])
            REG_MASK:    rdata = {4'h0, mask};
            REG_PENDING: rdata = {4'h0, pending};
            REG_CTRL:    rdata = {en, 6'd0, rr};
            REG_STATUS:  rdata = {(state != ST_IDLE), 5'd0, MCU_IRQ_ID};
            default:     rdata = 8'h00;
        endcase
    end

    assign BUS_DATA = (hit && !BUS_WE) ? rdata : 8'hzz;

    irq_arbiter u_arbiter (
        .req         (pending & mask),
        .rr_mode     (rr),
        .last_served (last_served),
        .grant_id    (grant_id),
        .valid       (grant_valid)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync1   <= 4'h0;
            sync2   <= 4'h0;
            sync3   <= 4'h0;
            pending <= 4'h0;
            mask    <= InitialMask;
            en      <= InitialEnable;
            rr      <= 1'b0;
        end else begin
            sync1   <= IRQ_RAISE;
            sync2   <= sync1;
            sync3   <= sync2;
            pending <= pending_nxt;
            mask    <= mask_nxt;
            en      <= en_nxt;
            rr      <= rr_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= ST_IDLE;
            MCU_IRQ     <= 1'b0;
            MCU_IRQ_ID  <= 2'd0;
            last_served <= 2'd3;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en && |(pending & mask))
                        state <= ST_ARB;
                end
                ST_ARB: begin
                    if (grant_valid) begin
                        MCU_IRQ_ID <= grant_id;
                        MCU_IRQ    <= 1'b1;
                        state      <= ST_ASSERT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ASSERT: begin
                    if (ack_fire) begin
                        last_served <= MCU_IRQ_ID;
                        MCU_IRQ     <= 1'b0;
                        state       <= ST_RELEASE;
                    end else if (!pending_nxt[MCU_IRQ_ID] || !mask_nxt[MCU_IRQ_ID] || !en_nxt) begin
                        // Source withdrawn: drop the request in the same edge as the register write
                        MCU_IRQ <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_RELEASE: begin
                    if (!MCU_IRQ_ACK)
                        state <= ST_IDLE;
                end
                default: begin
                    MCU_IRQ <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: latency, arbitration modes,
// masking, W1C/ACK races and asynchronous reset.
module tb_interrupt_controller;

    localparam logic [7:0] BASE = 8'hE0;

    logic       CLK;
    logic       RESET;
    wire  [7:0] BUS_DATA;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic [3:0] IRQ_RAISE;
    logic       MCU_IRQ;
    logic [1:0] MCU_IRQ_ID;
    logic       MCU_IRQ_ACK;
    logic [7:0] bus_drv;
    logic [7:0] rd;

    int n_vec = 0;
    int n_err = 0;

    assign BUS_DATA = BUS_WE ? bus_drv : 8'hzz;

    interrupt_controller #(
        .IntcBaseAddr  (BASE),
        .InitialMask   (4'hF),
        .InitialEnable (1'b1)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .BUS_DATA    (BUS_DATA),
        .BUS_ADDR    (BUS_ADDR),
        .BUS_WE      (BUS_WE),
        .IRQ_RAISE   (IRQ_RAISE),
        .MCU_IRQ     (MCU_IRQ),
        .MCU_IRQ_ID  (MCU_IRQ_ID),
        .MCU_IRQ_ACK (MCU_IRQ_ACK)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] off, input logic [7:0] data);
        BUS_ADDR = BASE + {6'd0, off};
        bus_drv  = data;
        BUS_WE   = 1'b1;
        tick();
        BUS_WE   = 1'b0;
        BUS_ADDR = 8'h00;
    endtask

    task automatic read_reg(input logic [1:0] off, output logic [7:0] data);
        BUS_ADDR = BASE + {6'd0, off};
        BUS_WE   = 1'b0;
        #1;
        data     = BUS_DATA;
        BUS_ADDR = 8'h00;
    endtask

    task automatic wait_irq(input string tag);
        int n = 0;
        while (!MCU_IRQ && n < 20) begin
            tick();
            n++;
        end
        check_vec({tag, "_irq"}, {7'd0, MCU_IRQ}, 8'h01);
    endtask

    task automatic serve(input logic [1:0] exp_id, input string tag);
        wait_irq(tag);
        check_vec({tag, "_id"}, {6'd0, MCU_IRQ_ID}, {6'd0, exp_id});
        MCU_IRQ_ACK = 1'b1;
        tick();
        check_vec({tag, "_drop"}, {7'd0, MCU_IRQ}, 8'h00);
        MCU_IRQ_ACK = 1'b0;
        tick();
    endtask

    initial begin
        RESET       = 1'b0;
        BUS_ADDR    = 8'h00;
        BUS_WE      = 1'b0;
        bus_drv     = 8'h00;
        IRQ_RAISE   = 4'h0;
        MCU_IRQ_ACK = 1'b0;
        repeat (3) tick();
        RESET = 1'b1;
        tick();

        // reset state
        check_vec("rst_irq", {7'd0, MCU_IRQ}, 8'h00);
        check_vec("rst_id", {6'd0, MCU_IRQ_ID}, 8'h00);
        read_reg(2'd0, rd); check_vec("rst_mask", rd, 8'h0F);
        read_reg(2'd1, rd); check_vec("rst_pend", rd, 8'h00);
        read_reg(2'd2, rd); check_vec("rst_ctrl", rd, 8'h80);
        read_reg(2'd3, rd); check_vec("rst_stat", rd, 8'h00);

        // latency on source 0, edge k is the next posedge
        IRQ_RAISE = 4'b0001;
        tick();
        tick();
        read_reg(2'd1, rd); check_vec("lat_pend_k1", rd, 8'h00);
        tick();
        read_reg(2'd1, rd); check_vec("lat_pend_k2", rd, 8'h01);
        check_vec("lat_irq_k2", {7'd0, MCU_IRQ}, 8'h00);
        IRQ_RAISE = 4'b0000;
        tick();
        check_vec("lat_irq_k3", {7'd0, MCU_IRQ}, 8'h00);
        tick();
        check_vec("lat_irq_k4", {7'd0, MCU_IRQ}, 8'h01);
        check_vec("lat_id", {6'd0, MCU_IRQ_ID}, 8'h00);
        read_reg(2'd1, rd); check_vec("lat_pend", rd, 8'h01);
        repeat (5) tick();
        check_vec("lat_hold", {7'd0, MCU_IRQ}, 8'h01);
        MCU_IRQ_ACK = 1'b1;
        tick();
        read_reg(2'd3, rd); check_vec("lat_stat_rel", rd, 8'h80);
        read_reg(2'd1, rd); check_vec("lat_pend_ack", rd, 8'h00);
        MCU_IRQ_ACK = 1'b0;
        tick();
        read_reg(2'd3, rd); check_vec("lat_stat_idle", rd, 8'h00);

        // fixed priority with sources 1 and 3 together
        IRQ_RAISE = 4'b1010;
        serve(2'd1, "fix_a");
        serve(2'd3, "fix_b");
        IRQ_RAISE = 4'b0000;
        repeat (3) tick();
        read_reg(2'd1, rd); check_vec("fix_pend", rd, 8'h00);

        // round-robin with last_served = 1
        write_reg(2'd2, 8'h81);
        read_reg(2'd2, rd); check_vec("rr_ctrl", rd, 8'h81);
        IRQ_RAISE = 4'b0010;
        serve(2'd1, "rr_seed");
        IRQ_RAISE = 4'b0000;
        repeat (3) tick();
        IRQ_RAISE = 4'b1111;
        serve(2'd2, "rr_0");
        serve(2'd3, "rr_1");
        serve(2'd0, "rr_2");
        serve(2'd1, "rr_3");
        IRQ_RAISE = 4'b0000;
        write_reg(2'd2, 8'h80);
        repeat (3) tick();

        // masking source 0
        write_reg(2'd0, 8'h0E);
        IRQ_RAISE = 4'b0001;
        repeat (6) tick();
        check_vec("mask_irq", {7'd0, MCU_IRQ}, 8'h00);
        read_reg(2'd1, rd); check_vec("mask_pend", rd, 8'h01);
        write_reg(2'd0, 8'h0F);
        check_vec("unmask_e0", {7'd0, MCU_IRQ}, 8'h00);
        tick();
        check_vec("unmask_e1", {7'd0, MCU_IRQ}, 8'h00);
        tick();
        check_vec("unmask_e2", {7'd0, MCU_IRQ}, 8'h01);
        check_vec("unmask_id", {6'd0, MCU_IRQ_ID}, 8'h00);
        MCU_IRQ_ACK = 1'b1;
        tick();
        MCU_IRQ_ACK = 1'b0;
        IRQ_RAISE = 4'b0000;
        repeat (3) tick();

        // W1C withdrawal during ASSERT
        IRQ_RAISE = 4'b0100;
        wait_irq("w1c");
        check_vec("w1c_id", {6'd0, MCU_IRQ_ID}, 8'h02);
        write_reg(2'd1, 8'h04);
        check_vec("w1c_drop", {7'd0, MCU_IRQ}, 8'h00);
        read_reg(2'd3, rd); check_vec("w1c_stat", rd, 8'h02);
        IRQ_RAISE = 4'b0000;
        repeat (4) tick();
        check_vec("w1c_quiet", {7'd0, MCU_IRQ}, 8'h00);

        // new edge on source 2 lands on the ACK clear
        IRQ_RAISE = 4'b0100;
        wait_irq("race");
        check_vec("race_id", {6'd0, MCU_IRQ_ID}, 8'h02);
        IRQ_RAISE = 4'b0000;
        repeat (3) tick();
        IRQ_RAISE = 4'b0100;
        tick();
        tick();
        MCU_IRQ_ACK = 1'b1;
        tick();
        read_reg(2'd1, rd); check_vec("race_pend", rd, 8'h04);
        check_vec("race_drop", {7'd0, MCU_IRQ}, 8'h00);
        MCU_IRQ_ACK = 1'b0;
        tick();
        serve(2'd2, "race_re");
        read_reg(2'd1, rd); check_vec("race_pend_end", rd, 8'h00);
        IRQ_RAISE = 4'b0000;
        repeat (3) tick();

        // asynchronous reset mid-ASSERT
        IRQ_RAISE = 4'b0010;
        wait_irq("arst");
        IRQ_RAISE = 4'b0000;
        #2;
        RESET = 1'b0;
        #1;
        check_vec("arst_irq", {7'd0, MCU_IRQ}, 8'h00);
        check_vec("arst_id", {6'd0, MCU_IRQ_ID}, 8'h00);
        tick();
        tick();
        RESET = 1'b1;
        tick();
        read_reg(2'd0, rd); check_vec("arst_mask", rd, 8'h0F);
        read_reg(2'd2, rd); check_vec("arst_ctrl", rd, 8'h80);
        repeat (4) tick();
        read_reg(2'd1, rd); check_vec("arst_pend", rd, 8'h00);
        check_vec("arst_quiet", {7'd0, MCU_IRQ}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 The block SHALL have parameter IntcBaseAddr, default 8'hE0, meaning the bus base address of its 4-register window.
REQ-002 The block SHALL have parameter InitialMask, default 4'hF, meaning the reset value of the mask register.
REQ-003 The block SHALL have parameter InitialEnable, default 1'b1, meaning the reset value of the global enable bit.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single system clock; all flops clock on its rising edge.
REQ-005 The block SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port BUS_DATA, inout, 8 bits: the shared data bus, tri-stated (8'hZZ) when not driven.
REQ-007 The block SHALL have port BUS_ADDR, input, 8 bits: the bus address.
REQ-008 The block SHALL have port BUS_WE, input, 1 bit: the bus write strobe.
REQ-009 The block SHALL have port IRQ_RAISE, input, 4 bits: peripheral interrupt lines (timer on bit 0), asynchronous to CLK.
REQ-010 The block SHALL have port MCU_IRQ, output, 1 bit: the interrupt request to the MCU.
REQ-011 The block SHALL have port MCU_IRQ_ID, output, 2 bits: the index of the source being served.
REQ-012 The block SHALL have port MCU_IRQ_ACK, input, 1 bit: the MCU acknowledge.

Function
REQ-013 Register map SHALL be: base+0 MASK[3:0] R/W (1 = source enabled); base+1 PENDING[3:0] RO, write-1-to-clear; base+2 CTRL bit7 EN, bit0 RR (0 = fixed priority, 1 = round-robin) R/W; base+3 STATUS bit7 busy, bits[1:0] active id, RO; unused bits read 0.
REQ-014 BUS_DATA SHALL be driven combinationally only when BUS_ADDR is in base..base+3 and BUS_WE=0; otherwise it SHALL be 8'hZZ.
REQ-015 Each IRQ_RAISE bit SHALL pass through a 2-flop synchronizer followed by rising-edge detection; a rising edge SHALL set its PENDING bit regardless of MASK.
REQ-016 A rising edge and a clear of the same PENDING bit in the same cycle (by W1C or ACK) SHALL leave the bit set.
REQ-017 The FSM SHALL have the states IDLE, ARB, ASSERT and RELEASE.
REQ-018 In IDLE, if EN=1 and (PENDING & MASK) != 0, the FSM SHALL go to ARB.
REQ-019 In ARB, the FSM SHALL register the winner into MCU_IRQ_ID and go to ASSERT.
REQ-020 In ASSERT, MCU_IRQ SHALL be 1; on MCU_IRQ_ACK=1, the FSM SHALL clear PENDING[id] and go to RELEASE.
REQ-021 In ASSERT, if PENDING[id] becomes 0 (W1C), MASK[id]=0, or EN=0, the FSM SHALL return to IDLE without an ACK.
REQ-022 In RELEASE, the FSM SHALL wait for MCU_IRQ_ACK=0 and then go to IDLE.
REQ-023 Arbitration in fixed-priority mode SHALL select the lowest index first.
REQ-024 Arbitration in round-robin mode SHALL start the search at last_served+1 mod 4; last_served SHALL update on each ACK.
REQ-025 MCU_IRQ SHALL be registered and equal to (state==ASSERT).
REQ-026 Latency SHALL be: IRQ_RAISE first sampled high at edge k gives PENDING set after edge k+2 and MCU_IRQ=1 after edge k+4, with the FSM in IDLE and the source unmasked.
REQ-027 Edges arriving while a source is already pending SHALL be coalesced into the single PENDING bit.
REQ-028 An ACK seen in IDLE, ARB or RELEASE SHALL be ignored.
REQ-029 STATUS.busy SHALL be 1 in the ARB, ASSERT and RELEASE states.

Reset
REQ-030 RESET=0 SHALL immediately set: state IDLE, MCU_IRQ=0, MCU_IRQ_ID=0, PENDING=0, MASK=InitialMask, EN=InitialEnable, RR=0, last_served=3, synchronizer and edge flops 0.
REQ-031 Reset asserted mid-ASSERT SHALL drop MCU_IRQ asynchronously, and no pending state SHALL survive it.

Structure
REQ-032 A shared package intc_pkg SHALL hold the FSM state encoding, the register offsets (0 to 3), NUM_SRC=4 and the CTRL bit positions.
REQ-033 The block SHALL contain one combinational sub-module, irq_arbiter, with inputs req[3:0], rr_mode and last_served[1:0], and outputs grant_id[1:0] and valid.

Verification
REQ-034 The bench SHALL check: IRQ_RAISE[0] pulse rising at edge 10, no ACK -> MCU_IRQ=1 after edge 14, ID=0, PENDING reads 4'h1.
REQ-035 The bench SHALL check: IRQ_RAISE=4'b1010 rising together, fixed mode, ACK each in turn -> served IDs 1 then 3, PENDING 4'h0 at end.
REQ-036 The bench SHALL check: RR=1, all four sources pending, last_served=1 -> service order 2,3,0,1.
REQ-037 The bench SHALL check: MASK=4'hE with source 0 pending -> MCU_IRQ stays 0; then write MASK=4'hF -> MCU_IRQ=1 after 2 edges, ID=0.
REQ-038 The bench SHALL check: in ASSERT, write 8'h04 to base+1 while ID=2 -> MCU_IRQ=0 next cycle and the FSM is in IDLE; a new edge on source 2 coinciding with the ACK clear -> PENDING[2] remains 1.
REQ-039 The bench SHALL check: RESET=0 pulsed mid-ASSERT -> MCU_IRQ=0 without a clock edge, and after release base+0 reads 8'h0F and base+2 reads 8'h80.
